// File: rtl/genius_fx_scheduler_if.sv
// Request/response bundle between the Genius game FSM (master) and the
// buzzer/LED effect scheduler (slave).
interface genius_fx_scheduler_if;
  // Handshakes: play_req is a level held by the master until play_ack (a
  // one-cycle pulse) and may be withdrawn earlier without effect; hold_en is
  // a level; jingle_req is a one-cycle pulse with jingle_win valid alongside;
  // play_done / jingle_done are one-cycle completion pulses.
  logic       play_req;
  logic [1:0] play_color;
  logic       play_ack;
  logic       play_done;
  logic       hold_en;
  logic [1:0] hold_color;
  logic       jingle_req;
  logic       jingle_win;
  logic       jingle_done;
  logic [2:0] tone;
  logic       buzzer_en;
  logic [1:0] led_color;
  logic       led_en;
  logic       busy;

  modport master (
    output play_req, play_color, hold_en, hold_color, jingle_req, jingle_win,
    input  play_ack, play_done, jingle_done, tone, buzzer_en, led_color, led_en, busy
  );

  modport slave (
    input  play_req, play_color, hold_en, hold_color, jingle_req, jingle_win,
    output play_ack, play_done, jingle_done, tone, buzzer_en, led_color, led_en, busy
  );
endinterface

// File: rtl/genius_fx_scheduler.sv
// Arbitrates sequence notes, held-button feedback and win/lose jingles onto
// the shared buzzer/LED outputs. Optional FX_MUTE_EN adds a buzzer mute input.
module genius_fx_scheduler #(
  parameter int NOTE_CYCLES   = 75000000,
  parameter int GAP_CYCLES    = 25000000,
  parameter int JINGLE_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                reset,
`ifdef FX_MUTE_EN
  input  logic                mute,
`endif
  genius_fx_scheduler_if.slave fx,
  output logic [2:0]          state_dbg
);

  localparam int MAX_NG  = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_NG > JINGLE_CYCLES) ? MAX_NG : JINGLE_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] NOTE_LOAD   = CW'(NOTE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] JINGLE_LOAD = CW'(JINGLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOLD   = 3'd1,
    S_NOTE   = 3'd2,
    S_GAP    = 3'd3,
    S_JINGLE = 3'd4
  } state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [1:0]      idx_q, idx_n;
  logic [1:0]      color_q, color_n;
  logic            win_q, win_n;
  logic            pend_q, pend_n;
  logic            pend_win_q, pend_win_n;
  logic            start_jingle;

  logic [2:0]      tone_q, tone_n;
  logic            buzzer_q, buzzer_n, buzzer_gated;
  logic [1:0]      led_color_q, led_color_n;
  logic            led_en_q, led_en_n;
  logic            ack_q, ack_n;
  logic            play_done_q, play_done_n;
  logic            jingle_done_q, jingle_done_n;
  logic            busy_q;

  // Win climbs 5,6,7; lose descends 7,6,5.
  function automatic logic [2:0] jingle_tone(input logic win, input logic [1:0] idx);
    return win ? (3'd5 + {1'b0, idx}) : (3'd7 - {1'b0, idx});
  endfunction

  always_comb begin
    state_n       = state_q;
    cnt_n         = cnt_q;
    idx_n         = idx_q;
    color_n       = color_q;
    win_n         = win_q;
    pend_n        = pend_q;
    pend_win_n    = pend_win_q;
    start_jingle  = 1'b0;
    tone_n        = 3'd0;
    buzzer_n      = 1'b0;
    led_color_n   = 2'd0;
    led_en_n      = 1'b0;
    ack_n         = 1'b0;
    play_done_n   = 1'b0;
    jingle_done_n = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fx.hold_en) begin
          state_n     = S_HOLD;
          tone_n      = {1'b0, fx.hold_color};
          led_color_n = fx.hold_color;
          buzzer_n    = 1'b1;
          led_en_n    = 1'b1;
        end else if (pend_q || fx.jingle_req) begin
          state_n      = S_JINGLE;
          start_jingle = 1'b1;
          win_n        = pend_q ? pend_win_q : fx.jingle_win;
          idx_n        = 2'd0;
          cnt_n        = JINGLE_LOAD;
          tone_n       = jingle_tone(win_n, 2'd0);
          buzzer_n     = 1'b1;
        end else if (fx.play_req) begin
          state_n     = S_NOTE;
          color_n     = fx.play_color;
          cnt_n       = NOTE_LOAD;
          ack_n       = 1'b1;
          tone_n      = {1'b0, fx.play_color};
          led_color_n = fx.play_color;
          buzzer_n    = 1'b1;
          led_en_n    = 1'b1;
        end
      end
      S_HOLD: begin
        if (fx.hold_en) begin
          tone_n      = {1'b0, fx.hold_color};
          led_color_n = fx.hold_color;
          buzzer_n    = 1'b1;
          led_en_n    = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_NOTE: begin
        if (cnt_q == '0) begin
          state_n = S_GAP;
          cnt_n   = GAP_LOAD;
        end else begin
          cnt_n       = cnt_q - CW'(1);
          tone_n      = {1'b0, color_q};
          led_color_n = color_q;
          buzzer_n    = 1'b1;
          led_en_n    = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_n     = S_IDLE;
          play_done_n = 1'b1;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      S_JINGLE: begin
        if (cnt_q == '0) begin
          if (idx_q == 2'd2) begin
            state_n       = S_IDLE;
            jingle_done_n = 1'b1;
          end else begin
            idx_n    = idx_q + 2'd1;
            cnt_n    = JINGLE_LOAD;
            tone_n   = jingle_tone(win_q, idx_q + 2'd1);
            buzzer_n = 1'b1;
          end
        end else begin
          cnt_n    = cnt_q - CW'(1);
          tone_n   = jingle_tone(win_q, idx_q);
          buzzer_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // One-deep pending slot: a request that cannot start now is parked,
    // later ones are dropped and the first win/lose choice is kept.
    if (start_jingle) begin
      pend_n = 1'b0;
    end else if (fx.jingle_req && !pend_q) begin
      pend_n     = 1'b1;
      pend_win_n = fx.jingle_win;
    end
  end

`ifdef FX_MUTE_EN
  assign buzzer_gated = buzzer_n & ~mute;
`else
  assign buzzer_gated = buzzer_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      color_q       <= 2'd0;
      win_q         <= 1'b0;
      pend_q        <= 1'b0;
      pend_win_q    <= 1'b0;
      tone_q        <= 3'd0;
      buzzer_q      <= 1'b0;
      led_color_q   <= 2'd0;
      led_en_q      <= 1'b0;
      ack_q         <= 1'b0;
      play_done_q   <= 1'b0;
      jingle_done_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      idx_q         <= idx_n;
      color_q       <= color_n;
      win_q         <= win_n;
      pend_q        <= pend_n;
      pend_win_q    <= pend_win_n;
      tone_q        <= tone_n;
      buzzer_q      <= buzzer_gated;
      led_color_q   <= led_color_n;
      led_en_q      <= led_en_n;
      ack_q         <= ack_n;
      play_done_q   <= play_done_n;
      jingle_done_q <= jingle_done_n;
      busy_q        <= (state_n != S_IDLE);
    end
  end

  assign fx.tone        = tone_q;
  assign fx.buzzer_en   = buzzer_q;
  assign fx.led_color   = led_color_q;
  assign fx.led_en      = led_en_q;
  assign fx.play_ack    = ack_q;
  assign fx.play_done   = play_done_q;
  assign fx.jingle_done = jingle_done_q;
  assign fx.busy        = busy_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_genius_fx_scheduler.sv
// Randomised + directed bench for genius_fx_scheduler against a queue-based
// model that expands each accepted request into its expected output frames.
module tb_genius_fx_scheduler;
  localparam int NC = 4;
  localparam int GC = 2;
  localparam int JC = 3;
  localparam int W  = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;
`ifdef FX_MUTE_EN
  logic       mute;
`endif

  genius_fx_scheduler_if fx();

  genius_fx_scheduler #(
    .NOTE_CYCLES  (NC),
    .GAP_CYCLES   (GC),
    .JINGLE_CYCLES(JC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef FX_MUTE_EN
    .mute     (mute),
`endif
    .fx       (fx),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_frame;
  int           fin;       // 0 none, 1 play_done due, 2 jingle_done due
  bit           hold_act;
  bit           pend;
  bit           pwin;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;

  // Frame layout: busy, jingle_done, play_done, ack, led_en, led_color, buzzer_en, tone
  function automatic logic [W-1:0] mk(input logic busy, input logic jd, input logic pd,
                                      input logic ack, input logic len, input logic [1:0] lc,
                                      input logic buz, input logic [2:0] tn);
    return {busy, jd, pd, ack, len, lc, buz, tn};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic [W-1:0] f;
    bit started;
    bit pend0;
    bit w;
    logic [2:0] jt;
    started = 1'b0;
    pend0   = pend;
    f       = '0;
    if (reset) begin
      exp_q.delete();
      fin = 0; hold_act = 1'b0; pend = 1'b0; pwin = 1'b0;
    end else begin
      if (hold_act) begin
        if (fx.hold_en) f = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, fx.hold_color, 1'b1, {1'b0, fx.hold_color});
        else hold_act = 1'b0;
      end else if (exp_q.size() > 0) begin
        f = exp_q.pop_front();
      end else if (fin != 0) begin
        f = mk(1'b0, fin == 2, fin == 1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
        fin = 0;
      end else if (fx.hold_en) begin
        hold_act = 1'b1;
        f = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, fx.hold_color, 1'b1, {1'b0, fx.hold_color});
      end else if (pend || fx.jingle_req) begin
        w = pend ? pwin : fx.jingle_win;
        for (int i = 0; i < 3; i++) begin
          jt = w ? 3'(5 + i) : 3'(7 - i);
          for (int k = 0; k < JC; k++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, jt));
        end
        pend = 1'b0; started = 1'b1; fin = 2;
        f = exp_q.pop_front();
      end else if (fx.play_req) begin
        for (int k = 0; k < NC; k++)
          exp_q.push_back(mk(1'b1, 1'b0, 1'b0, k == 0, 1'b1, fx.play_color, 1'b1, {1'b0, fx.play_color}));
        for (int k = 0; k < GC; k++)
          exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0));
        fin = 1;
        f = exp_q.pop_front();
      end
      if (fx.jingle_req && !started && !pend0) begin
        pend = 1'b1;
        pwin = fx.jingle_win;
      end
    end
`ifdef FX_MUTE_EN
    if (mute) f[3] = 1'b0;
`endif
    exp_frame = f;
  endtask

  // driver: one clock, model at the edge, compare at the falling edge
  task automatic cycle();
    logic [W-1:0] act;
    @(posedge clk);
    model_step();
    @(negedge clk);
    act = {fx.busy, fx.jingle_done, fx.play_done, fx.play_ack, fx.led_en,
           fx.led_color, fx.buzzer_en, fx.tone};
    check("outputs", act, exp_frame);
    check("state_idle", W'(state_dbg == 3'd0), W'(!exp_frame[10]));
    cyc++;
    fx.jingle_req = 1'b0;
    if (fx.play_ack) fx.play_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic scenario_note(input logic [1:0] c);
    fx.play_color = c;
    fx.play_req   = 1'b1;
    run(10);
  endtask

  initial begin
    bit w;
    fx.play_req = 1'b0; fx.play_color = 2'd0; fx.hold_en = 1'b0; fx.hold_color = 2'd0;
    fx.jingle_req = 1'b0; fx.jingle_win = 1'b0;
`ifdef FX_MUTE_EN
    mute = 1'b0;
`endif
    fin = 0; hold_act = 1'b0; pend = 1'b0; pwin = 1'b0;
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(2);

    // sequence note, then the same with mute where present
    scenario_note(2'd2);
`ifdef FX_MUTE_EN
    mute = 1'b1;
    scenario_note(2'd2);
    mute = 1'b0;
`endif
    scenario_note(2'($urandom_range(0, 3)));

    // win then lose jingle
    fx.jingle_win = 1'b1; fx.jingle_req = 1'b1; run(12);
    fx.jingle_win = 1'b0; fx.jingle_req = 1'b1; run(12);

    // held button with a colour change
    fx.hold_color = 2'd0; fx.hold_en = 1'b1; run(5);
    fx.hold_color = 2'd3; run(4);
    fx.hold_en = 1'b0; run(3);

    // simultaneous requests; second jingle during hold must be dropped
    w = 1'($urandom_range(0, 1));
    fx.hold_en = 1'b1; fx.hold_color = 2'($urandom_range(0, 3));
    fx.jingle_req = 1'b1; fx.jingle_win = w;
    fx.play_req = 1'b1; fx.play_color = 2'($urandom_range(0, 3));
    run(4);
    fx.jingle_req = 1'b1; fx.jingle_win = ~w; run(4);
    fx.hold_en = 1'b0; run(25);

    // reset mid-note with a pending jingle
    fx.play_color = 2'($urandom_range(0, 3)); fx.play_req = 1'b1;
    run(2);
    fx.jingle_req = 1'b1; fx.jingle_win = 1'($urandom_range(0, 1));
    run(1);
    reset = 1'b1; run(1);
    reset = 1'b0; run(15);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (fx.hold_en) begin
        if ($urandom_range(0, 99) < 20) fx.hold_en = 1'b0;
      end else if ($urandom_range(0, 99) < 3) begin
        fx.hold_en = 1'b1;
      end
      fx.hold_color = 2'($urandom_range(0, 3));
      if (!fx.play_req) begin
        if ($urandom_range(0, 99) < 15) begin
          fx.play_req = 1'b1;
          fx.play_color = 2'($urandom_range(0, 3));
        end
      end else if ($urandom_range(0, 99) < 3) begin
        fx.play_req = 1'b0;
      end
      fx.jingle_req = ($urandom_range(0, 99) < 4);
      fx.jingle_win = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 199) == 0);
`ifdef FX_MUTE_EN
      if ($urandom_range(0, 99) < 10) mute = ~mute;
`endif
      cycle();
    end
    reset = 1'b0;
    run(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/genius_fx_scheduler.md
Name: genius_fx_scheduler

Overview:
- Owns the shared buzzer tone and LED colour outputs of the Genius game and arbitrates three requesters.
- Requesters: timed sequence notes from the genius playback, held player-press feedback, and three-note win/lose jingles.
- Replaces per-state ad-hoc driving of tone/buzzerEn/cor/ledEn in the top-level FSM.
- Sits between the game FSM and the buzzer / led_ctrl instances.

Parameters:
- NOTE_CYCLES, 75000000, clocks a sequence note sounds (0.75 s at 100 MHz); must be >= 1.
- GAP_CYCLES, 25000000, silent clocks after each sequence note; must be >= 1.
- JINGLE_CYCLES, 50000000, clocks per jingle tone; must be >= 1.
- Internal down-counter width is $clog2(max of the three + 1).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- play_req  in  1  level; request one sequence note, held until play_ack
- play_color  in  2  colour code 0..3; sampled on acceptance
- play_ack  out  1  one-cycle pulse; note accepted
- play_done  out  1  one-cycle pulse; note plus gap finished
- hold_en  in  1  level; player button held
- hold_color  in  2  colour of held button; tracked every cycle
- jingle_req  in  1  one-cycle pulse; start jingle
- jingle_win  in  1  1 = win (tones 5,6,7), 0 = lose (tones 7,6,5); sampled with jingle_req
- jingle_done  out  1  one-cycle pulse; jingle finished
- tone  out  3  tone code to buzzer
- buzzer_en  out  1  buzzer enable
- led_color  out  2  colour to led_ctrl
- led_en  out  1  LED enable
- busy  out  1  state != IDLE

Behaviour:
- All outputs are registered.
- Reset values: tone=0, led_color=0, buzzer_en=0, led_en=0, play_ack=0, play_done=0, jingle_done=0, busy=0, state=IDLE, jingle pending flag=0, down-counter=0.
- States: IDLE, HOLD, NOTE, GAP, JINGLE. JINGLE uses a 2-bit index 0..2.
- IDLE arbitration runs every IDLE cycle. Priority: hold_en > pending jingle (or jingle_req this cycle) > play_req.
- IDLE outputs: buzzer_en=0, led_en=0, tone=0.
- HOLD:
  - Entered the cycle after hold_en is seen high.
  - tone={1'b0,hold_color}, led_color=hold_color, buzzer_en=1, led_en=1.
  - hold_color changes are reflected with 1-cycle latency.
  - hold_en low moves to IDLE next cycle with outputs off.
  - No done pulse.
- NOTE:
  - On acceptance, play_color is latched and the counter is loaded with NOTE_CYCLES-1.
  - Next cycle: state=NOTE, play_ack=1 (single cycle), buzzer_en=1, led_en=1, tone={1'b0,colour}, led_color=colour.
  - NOTE lasts exactly NOTE_CYCLES cycles.
  - Then GAP for exactly GAP_CYCLES cycles with buzzer_en=0 and led_en=0.
  - play_done=1 on the first IDLE cycle after GAP. That cycle arbitrates normally, so back-to-back notes are separated by GAP_CYCLES+1 silent cycles.
- JINGLE:
  - Three tones of JINGLE_CYCLES each, no gaps, led_en=0, buzzer_en=1.
  - Tones are 5,6,7 (win) or 7,6,5 (lose).
  - jingle_done=1 on the first IDLE cycle after tone index 2 expires.
- jingle_req while busy:
  - Sets a one-deep pending flag and latches jingle_win.
  - Further jingle_req while pending are dropped; the first jingle_win is kept.
  - The pending flag clears when the jingle starts.
- Any request that arrives while not IDLE is not preempting.
  - hold_en during NOTE/GAP/JINGLE waits for IDLE.
  - play_req stays unacknowledged until IDLE and the arbitration win.
- play_req dropped before play_ack: no note is played and no error is raised.
- A continuously asserted hold_en starves other requesters. This is intended, since the player owns the buzzer while pressing.
- reset mid-operation:
  - Immediate return to IDLE with all outputs at reset values.
  - No done pulses; pending jingle is cleared.
- Counter terminal condition is ==0. There is no wrap-around, because the counter is reloaded before it underflows.

Optional Feature:
- FX_MUTE_EN: adds input mute (1 bit).
- Defined:
  - While mute=1, buzzer_en is forced to 0 in every state.
  - State sequencing, led_en, tone values and all handshake timing are unchanged.
- Undefined: no mute port; buzzer_en is exactly as described above.

Test Plan:
1. NOTE_CYCLES=4, GAP_CYCLES=2; play_req=1, play_color=2 at cycle 0 in IDLE.
   - Cycle 1: play_ack=1.
   - Cycles 1-4: buzzer_en=1, led_en=1, tone=2, led_color=2.
   - Cycles 5-6: outputs off.
   - Cycle 7: play_done=1, busy=0.
2. JINGLE_CYCLES=3; jingle_req=1, jingle_win=1 in IDLE.
   - Tone sequence is 5,5,5,6,6,6,7,7,7 with led_en=0.
   - jingle_done one cycle after the last 7.
   - Repeat with jingle_win=0 and expect 7,7,7,6,6,6,5,5,5.
3. hold_en=1 with hold_color=0, then hold_color=3 after 5 cycles, then hold_en=0.
   - tone/led_color go 0 then 3 (1-cycle lag).
   - IDLE one cycle after release; no done pulse.
4. Simultaneous hold_en=1, jingle_req=1, play_req=1 in IDLE.
   - HOLD is entered first.
   - On release: jingle plays, then play_ack.
   - A second jingle_req during HOLD is dropped (only one jingle_done).
5. reset asserted mid-NOTE (cycle 2 of 4).
   - Next cycle all outputs are 0 and state is IDLE.
   - No play_done; a pending jingle set before the reset never plays.
6. With FX_MUTE_EN and mute=1, repeat scenario 1.
   - buzzer_en=0 throughout.
   - led_en, play_ack and play_done timing are identical to scenario 1.
